immediate_reader: RTL and testbench
===================================

IMMEDIATE_READER -- requirements
Module: immediate_reader

Interface
REQ-001 SHALL have parameter IP_RESET, default 16'h0000, IP value loaded on reset.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have fifo_rd_en  output  1  pops one byte from the instruction-stream FIFO.
REQ-005 SHALL have fifo_rd_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 SHALL have fifo_empty  input  1  FIFO holds no bytes.
REQ-007 SHALL have start  input  1  request one immediate read; sampled only in IDLE.
REQ-008 SHALL have is_8bit  input  1  1 = one byte, 0 = two bytes little-endian; sampled with start.
REQ-009 SHALL have sign_extend  input  1  sign-extend an 8-bit read to 16 bits; sampled with start.
REQ-010 SHALL have flush  input  1  abort in-progress read and load new_ip.
REQ-011 SHALL have new_ip  input  16  IP loaded on flush.
REQ-012 SHALL have immed  output  16  assembled value, held until the next completion or reset.
REQ-013 SHALL have complete  output  1  one-cycle pulse; immed is valid.
REQ-014 SHALL have busy  output  1  high in every state except IDLE.
REQ-015 SHALL have ip  output  16  address of the next unconsumed instruction byte.

Function
REQ-016 FSM states SHALL be IDLE, FETCH_LO, CAPT_LO, FETCH_HI, CAPT_HI.
REQ-017 IDLE: start=1 and flush=0 SHALL latch is_8bit and sign_extend and go to FETCH_LO; start=0 stays in IDLE.
REQ-018 FETCH_x: fifo_rd_en SHALL equal !fifo_empty && !flush; the state SHALL advance to CAPT_x only when fifo_rd_en=1, and SHALL hold otherwise.
REQ-019 fifo_rd_en SHALL be 0 in IDLE, CAPT_LO and CAPT_HI.
REQ-020 CAPT_LO SHALL register fifo_rd_data as the low byte; the next state SHALL be IDLE for an 8-bit read and FETCH_HI for a 16-bit read.
REQ-021 CAPT_HI SHALL register fifo_rd_data as the high byte; the next state SHALL be IDLE.
REQ-022 On the edge leaving the final CAPT state, immed SHALL update and complete SHALL be 1 for exactly the following cycle.
REQ-023 immed SHALL be {hi,lo} for a 16-bit read, {{8{lo[7]}},lo} for an 8-bit read with sign_extend=1, and {8'h00,lo} for an 8-bit read with sign_extend=0.
REQ-024 Latency with a non-empty FIFO, start sampled at edge E0: 8-bit complete SHALL be high in the cycle after E2; 16-bit in the cycle after E4.
REQ-025 ip SHALL increment by 1, modulo 2^16, on every CAPT edge; 16'hFFFF+1 SHALL give 16'h0000.
REQ-026 start while busy SHALL be ignored, with no queueing.
REQ-027 flush SHALL take effect in any state: next state IDLE, ip <= new_ip, no complete, immed unchanged, and any byte popped but not captured SHALL be discarded.
REQ-028 flush and start in the same cycle: flush SHALL win and start SHALL be dropped.
REQ-029 complete SHALL be 0 in the cycle after a flush even if a CAPT edge coincided with the flush.
REQ-030 At most one FIFO pop SHALL be outstanding; fifo_rd_en SHALL never assert on consecutive cycles.

Reset
REQ-031 Asserting reset SHALL force, asynchronously: state IDLE, ip=IP_RESET, immed=16'h0000, complete=0, busy=0, fifo_rd_en=0.
REQ-032 Reset mid-read SHALL abandon the read with no complete after reset deasserts; any popped byte is lost.
REQ-033 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-034 FIFO=[0x85], ip=0x0100, start, is_8bit=1, sign_extend=1 -> complete two cycles after the start edge, immed=0xFF85, ip=0x0101, exactly one fifo_rd_en pulse.
REQ-035 FIFO=[0x34,0x12], start, is_8bit=0 -> immed=0x1234, one complete pulse, ip advanced by 2, two non-adjacent fifo_rd_en pulses.
REQ-036 16-bit read, fifo_empty=1 for 5 cycles in FETCH_HI -> fifo_rd_en=0 and busy=1 throughout; completes when 0x12 arrives; immed correct.
REQ-037 flush with new_ip=0x2000 in CAPT_HI -> no complete, busy=0 next cycle, ip=0x2000, immed keeps its previous value.
REQ-038 ip=0xFFFF, 16-bit read -> ip=0x0001; same-cycle start+flush in IDLE -> remains IDLE, ip=new_ip.
REQ-039 reset pulse in FETCH_HI -> all outputs at reset values; a subsequent 8-bit read completes normally.

Source files
------------

// File: rtl/immediate_reader_if.sv
// Signal bundle between an instruction-stream FIFO, the requesting core and the
// immediate reader; the reader attaches through the slave modport.
interface immediate_reader_if;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        start;
    logic        is_8bit;
    logic        sign_extend;
    logic        flush;
    logic [15:0] new_ip;
    logic [15:0] immed;
    logic        complete;
    logic        busy;
    logic [15:0] ip;

    modport master (
        input  fifo_rd_en, immed, complete, busy, ip,
        output fifo_rd_data, fifo_empty, start, is_8bit, sign_extend, flush, new_ip
    );

    modport slave (
        output fifo_rd_en, immed, complete, busy, ip,
        input  fifo_rd_data, fifo_empty, start, is_8bit, sign_extend, flush, new_ip
    );
endinterface

// File: rtl/immediate_reader.sv
// Reads a one- or two-byte little-endian immediate from the instruction-stream
// FIFO, tracks the instruction pointer and supports flush-to-new-IP.
module immediate_reader #(
    parameter logic [15:0] IP_RESET = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    immediate_reader_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        CAPT_LO  = 3'd2,
        FETCH_HI = 3'd3,
        CAPT_HI  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        rd_en_s;
    logic        accept_s;
    logic        capt_lo_s;
    logic        capt_hi_s;
    logic        is_8bit_r;
    logic        sext_r;
    logic [7:0]  lo_r;
    logic [15:0] ip_r;
    logic [15:0] immed_r;
    logic        complete_r;
    logic [15:0] immed_next_s;
    logic        complete_next_s;

    // Next-state and FIFO pop decode; flush pre-empts every state.
    always_comb begin
        state_next_s = state_r;
        rd_en_s      = 1'b0;
        accept_s     = 1'b0;
        capt_lo_s    = 1'b0;
        capt_hi_s    = 1'b0;
        if (bus.flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        accept_s     = 1'b1;
                        state_next_s = FETCH_LO;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                FETCH_LO: begin
                    rd_en_s = !bus.fifo_empty;
                    if (rd_en_s) begin
                        state_next_s = CAPT_LO;
                    end else begin
                        state_next_s = FETCH_LO;
                    end
                end
                CAPT_LO: begin
                    capt_lo_s = 1'b1;
                    if (is_8bit_r) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    rd_en_s = !bus.fifo_empty;
                    if (rd_en_s) begin
                        state_next_s = CAPT_HI;
                    end else begin
                        state_next_s = FETCH_HI;
                    end
                end
                CAPT_HI: begin
                    capt_hi_s    = 1'b1;
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Result assembly for the final capture edge of a read.
    always_comb begin
        immed_next_s    = immed_r;
        complete_next_s = 1'b0;
        if (capt_hi_s) begin
            immed_next_s    = {bus.fifo_rd_data, lo_r};
            complete_next_s = 1'b1;
        end else if (capt_lo_s && is_8bit_r) begin
            complete_next_s = 1'b1;
            if (sext_r) begin
                immed_next_s = {{8{bus.fifo_rd_data[7]}}, bus.fifo_rd_data};
            end else begin
                immed_next_s = {8'h00, bus.fifo_rd_data};
            end
        end else begin
            immed_next_s    = immed_r;
            complete_next_s = 1'b0;
        end
    end

    // State, read-mode latch and low-byte holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            is_8bit_r <= 1'b0;
            sext_r    <= 1'b0;
            lo_r      <= 8'h00;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                is_8bit_r <= bus.is_8bit;
                sext_r    <= bus.sign_extend;
            end else begin
                is_8bit_r <= is_8bit_r;
                sext_r    <= sext_r;
            end
            if (capt_lo_s) begin
                lo_r <= bus.fifo_rd_data;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    // Instruction pointer and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_r       <= IP_RESET;
            immed_r    <= 16'h0000;
            complete_r <= 1'b0;
        end else begin
            if (bus.flush) begin
                ip_r <= bus.new_ip;
            end else if (capt_lo_s || capt_hi_s) begin
                ip_r <= ip_r + 16'h0001;
            end else begin
                ip_r <= ip_r;
            end
            immed_r    <= immed_next_s;
            complete_r <= complete_next_s;
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.busy       = (state_r != IDLE);
    assign bus.ip         = ip_r;
    assign bus.immed      = immed_r;
    assign bus.complete   = complete_r;

endmodule

// File: tb/tb_immediate_reader.sv
// Directed self-checking bench for immediate_reader with a simple FIFO model.
module tb_immediate_reader;

    logic clk;
    logic reset;
    int   tests;
    int   failures;

    logic [7:0] fifo_mem [0:63];
    int         wr_ptr;
    int         rd_ptr;
    int         pops;
    int         adj_err;
    logic       prev_rd_en;

    immediate_reader_if bus ();

    immediate_reader #(.IP_RESET(16'h0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model: data valid the cycle after a pop; also flags back-to-back pops.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
            pops             <= pops + 1;
        end
        if (bus.fifo_rd_en && prev_rd_en) adj_err <= adj_err + 1;
        prev_rd_en <= bus.fifo_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int p0;
        tests = 0; failures = 0;
        wr_ptr = 0; rd_ptr = 0; pops = 0; adj_err = 0; prev_rd_en = 1'b0;
        bus.fifo_rd_data = 8'h00;
        bus.start = 1'b0; bus.is_8bit = 1'b0; bus.sign_extend = 1'b0;
        bus.flush = 1'b0; bus.new_ip = 16'h0000;
        reset = 1'b1;
        tick(); tick();
        check("rst_ip", bus.ip, 16'h0100);
        check("rst_immed", bus.immed, 16'h0000);
        check("rst_complete", {15'd0, bus.complete}, 16'h0000);
        check("rst_busy", {15'd0, bus.busy}, 16'h0000);
        check("rst_rd_en", {15'd0, bus.fifo_rd_en}, 16'h0000);

        // 8-bit sign-extended read, start on first edge after reset
        push(8'h85);
        reset = 1'b0;
        bus.start = 1'b1; bus.is_8bit = 1'b1; bus.sign_extend = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t1_busy", {15'd0, bus.busy}, 16'h0001);
        check("t1_rd_en", {15'd0, bus.fifo_rd_en}, 16'h0001);
        tick();
        check("t1_no_complete_early", {15'd0, bus.complete}, 16'h0000);
        tick();
        check("t1_complete", {15'd0, bus.complete}, 16'h0001);
        check("t1_immed", bus.immed, 16'hFF85);
        check("t1_ip", bus.ip, 16'h0101);
        check("t1_busy_after", {15'd0, bus.busy}, 16'h0000);
        tick();
        check("t1_complete_pulse", {15'd0, bus.complete}, 16'h0000);
        check("t1_pops", pops[15:0], 16'd1);

        // 16-bit little-endian read
        push(8'h34); push(8'h12);
        bus.start = 1'b1; bus.is_8bit = 1'b0; bus.sign_extend = 1'b0;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("t2_no_complete_e3", {15'd0, bus.complete}, 16'h0000);
        tick();
        check("t2_complete", {15'd0, bus.complete}, 16'h0001);
        check("t2_immed", bus.immed, 16'h1234);
        check("t2_ip", bus.ip, 16'h0103);
        tick();
        check("t2_complete_pulse", {15'd0, bus.complete}, 16'h0000);
        check("t2_pops", pops[15:0], 16'd3);

        // 16-bit read stalled on an empty FIFO in FETCH_HI
        push(8'h78);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_rd_en", {15'd0, bus.fifo_rd_en}, 16'h0000);
            check("t3_stall_busy", {15'd0, bus.busy}, 16'h0001);
            tick();
        end
        push(8'h12);
        tick(); tick();
        check("t3_complete", {15'd0, bus.complete}, 16'h0001);
        check("t3_immed", bus.immed, 16'h1278);
        check("t3_ip", bus.ip, 16'h0105);
        tick();

        // flush while in CAPT_HI
        push(8'hAB); push(8'hCD);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        bus.flush = 1'b1; bus.new_ip = 16'h2000;
        tick();
        bus.flush = 1'b0;
        check("t4_no_complete", {15'd0, bus.complete}, 16'h0000);
        check("t4_busy", {15'd0, bus.busy}, 16'h0000);
        check("t4_ip", bus.ip, 16'h2000);
        check("t4_immed_held", bus.immed, 16'h1278);

        // ip wrap across 16'hFFFF
        bus.flush = 1'b1; bus.new_ip = 16'hFFFF;
        tick();
        bus.flush = 1'b0;
        check("t5_ip_load", bus.ip, 16'hFFFF);
        push(8'h01); push(8'h02);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("t5_complete", {15'd0, bus.complete}, 16'h0001);
        check("t5_immed", bus.immed, 16'h0201);
        check("t5_ip_wrap", bus.ip, 16'h0001);

        // same-cycle start and flush in IDLE: flush wins
        bus.start = 1'b1; bus.flush = 1'b1; bus.new_ip = 16'h3000;
        push(8'h44);
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        check("t5_sf_busy", {15'd0, bus.busy}, 16'h0000);
        check("t5_sf_ip", bus.ip, 16'h3000);
        check("t5_sf_rd_en", {15'd0, bus.fifo_rd_en}, 16'h0000);
        tick();
        check("t5_sf_still_idle", {15'd0, bus.busy}, 16'h0000);
        check("t5_sf_no_complete", {15'd0, bus.complete}, 16'h0000);

        // reset pulse in FETCH_HI (0x44 becomes the low byte)
        bus.start = 1'b1; bus.is_8bit = 1'b0;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("t6_in_fetch_hi", {15'd0, bus.busy}, 16'h0001);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", {15'd0, bus.busy}, 16'h0000);
        check("t6_rst_ip", bus.ip, 16'h0100);
        check("t6_rst_immed", bus.immed, 16'h0000);
        check("t6_rst_complete", {15'd0, bus.complete}, 16'h0000);
        check("t6_rst_rd_en", {15'd0, bus.fifo_rd_en}, 16'h0000);
        tick();
        reset = 1'b0;
        push(8'h7F);
        tick(); tick(); tick();
        check("t6_no_late_complete", {15'd0, bus.complete}, 16'h0000);
        check("t6_idle", {15'd0, bus.busy}, 16'h0000);
        bus.start = 1'b1; bus.is_8bit = 1'b1; bus.sign_extend = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("t6_complete", {15'd0, bus.complete}, 16'h0001);
        check("t6_immed", bus.immed, 16'h007F);
        check("t6_ip", bus.ip, 16'h0101);

        // 8-bit zero-extended read with start held while busy
        push(8'h90); push(8'hEE);
        p0 = pops;
        bus.start = 1'b1; bus.sign_extend = 1'b0;
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        check("t7_complete", {15'd0, bus.complete}, 16'h0001);
        check("t7_immed", bus.immed, 16'h0090);
        tick(); tick(); tick();
        check("t7_no_queue_busy", {15'd0, bus.busy}, 16'h0000);
        check("t7_no_queue_pops", (pops - p0), 16'd1);
        check("t7_ip", bus.ip, 16'h0102);
        check("no_adjacent_pops", adj_err[15:0], 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
